sea_chunk_ctrl: RTL

SEA_CHUNK_CTRL -- requirements
Module: sea_chunk_ctrl

---
 rtl/sea_chunk_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sea_chunk_ctrl.sv
// Chunk sequencer for a SEA encrypt/decrypt core: load, run, drain and clear one chunk at a time.
// Optional SEA_CTRL_CHECK_EN adds a sticky mismatch flag comparing decrypted output to the input.
module sea_chunk_ctrl #(
  parameter int unsigned CHUNK_W = 256,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_chunks,
  input  logic [15:0]        no_of_round_cfg,
  input  logic [CHUNK_W-1:0] key_cfg,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [CHUNK_W-1:0] out_enc,
  output logic [CHUNK_W-1:0] out_dec,
  input  logic               out_ready,
  output logic               core_data_rdy,
  output logic [CHUNK_W-1:0] core_data_in,
  output logic [CHUNK_W-1:0] core_key_in,
  output logic [15:0]        core_no_of_round,
  input  logic               core_enc_complete,
  input  logic               core_dec_complete,
  input  logic [CHUNK_W-1:0] core_enc_data,
  input  logic [CHUNK_W-1:0] core_dec_data,
  output logic               busy,
  output logic               done
`ifdef SEA_CTRL_CHECK_EN
  ,
  output logic               mismatch
`endif
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StClear, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, num_q;
  logic [CHUNK_W-1:0]   data_q, key_q, enc_q, dec_q;
  logic [15:0]          rounds_q;
  logic                 in_ready_q, out_valid_q, rdy_q, busy_q, done_q;
  logic                 both_done, both_clear;

  assign both_done  = core_enc_complete & core_dec_complete;
  assign both_clear = ~core_enc_complete & ~core_dec_complete;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_chunks == '0) ? StDone : StLoad;
      StLoad:  if (in_valid) state_d = StRun;
      StRun:   if (both_done) state_d = StDrain;
      StDrain: if (out_ready) state_d = StClear;
      // Counter was already bumped on leaving DRAIN, so it compares directly to the job size.
      StClear: if (both_clear) state_d = (cnt_q == num_q) ? StDone : StLoad;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      num_q       <= '0;
      data_q      <= '0;
      key_q       <= '0;
      enc_q       <= '0;
      dec_q       <= '0;
      rounds_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == StLoad);
      out_valid_q <= (state_d == StDrain);
      rdy_q       <= (state_d == StRun);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      if (state_q == StIdle && start && num_chunks != '0) begin
        num_q    <= num_chunks;
        key_q    <= key_cfg;
        rounds_q <= no_of_round_cfg;
        cnt_q    <= '0;
      end
      if (state_q == StLoad && in_valid) data_q <= in_data;
      if (state_q == StRun && both_done) begin
        enc_q <= core_enc_data;
        dec_q <= core_dec_data;
      end
      if (state_q == StDrain && out_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SEA_CTRL_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      mis_q <= 1'b0;
    end else if (state_q == StDrain && dec_q != data_q) begin
      mis_q <= 1'b1;
    end
  end

  assign mismatch = mis_q;
`endif

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_enc          = enc_q;
  assign out_dec          = dec_q;
  assign core_data_rdy    = rdy_q;
  assign core_data_in     = data_q;
  assign core_key_in      = key_q;
  assign core_no_of_round = rounds_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
